// File: rtl/video_buffer_writer_pkg.sv
// Shared types and constants for the video buffer download writer.
package video_pkg;

    localparam int unsigned FRAME_WORDS = 19200;
    localparam int unsigned VBW_ADDR_W  = 15;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        REQ,
        RELEASE,
        DONE
    } vbw_state_t;

endpackage

// File: rtl/video_buffer_writer_if.sv
// Write port between the buffer writer (master) and the video block (slave).
interface video_buffer_writer_if;

    logic [31:0] data_out;
    logic [31:0] addr_out;
    logic        data_write;
    logic        data_ack;

    modport master (
        output data_out,
        output addr_out,
        output data_write,
        input  data_ack
    );

    modport slave (
        input  data_out,
        input  addr_out,
        input  data_write,
        output data_ack
    );

endinterface

// File: rtl/video_buffer_writer_packer.sv
// Packs four bytes little-endian into a 32-bit word; can also be loaded directly.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        collect,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] idx;
    logic       accept;

    assign byte_ready = collect;
    assign accept     = collect && byte_valid;
    assign word_valid = accept && (idx == 2'd3);

    // Byte index and word register; the 2-bit index wraps to 0 after the fourth byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (load) begin
            idx  <= '0;
            word <= load_word;
        end else if (clear) begin
            idx  <= '0;
        end else if (accept) begin
            word[{idx, 3'b000} +: 8] <= byte_data;
            idx                      <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/video_buffer_writer.sv
// Streams bytes (or a fill colour) into the video frame buffer via a 4-phase handshake.
module video_buffer_writer
    import video_pkg::*;
#(
    parameter int unsigned WORDS       = FRAME_WORDS,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                         system_clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         fill,
    input  logic [23:0]                  fill_color,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    video_buffer_writer_if.master        video_bus,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [VBW_ADDR_W-1:0] LAST_ADDR = VBW_ADDR_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    vbw_state_t            state, state_n;
    logic [VBW_ADDR_W-1:0] addr, addr_n;
    logic [VBW_ADDR_W-1:0] addr_hold, addr_hold_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  write, write_n;
    logic                  error_n;
    logic                  fill_mode, fill_mode_n;
    logic                  pk_clear, pk_load, word_valid;
    logic [31:0]           word;

    byte_word_packer packer (
        .clk        (system_clock),
        .rst        (reset),
        .collect    (state == COLLECT),
        .clear      (pk_clear),
        .load       (pk_load),
        .load_word  ({8'h00, fill_color}),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .word       (word),
        .word_valid (word_valid)
    );

    assign video_bus.data_out   = word;
    assign video_bus.addr_out   = {{(32 - VBW_ADDR_W){1'b0}}, addr_hold};
    assign video_bus.data_write = write;
    assign busy                 = (state != IDLE);
    assign done                 = (state == DONE);

    // State and datapath registers.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            addr_hold <= '0;
            cnt       <= '0;
            write     <= 1'b0;
            error     <= 1'b0;
            fill_mode <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            addr_hold <= addr_hold_n;
            cnt       <= cnt_n;
            write     <= write_n;
            error     <= error_n;
            fill_mode <= fill_mode_n;
        end
    end

    // Next-state logic: handshake sequencing, address advance and ack timeout.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        addr_hold_n = addr_hold;
        cnt_n       = cnt;
        write_n     = write;
        error_n     = error;
        fill_mode_n = fill_mode;
        pk_clear    = 1'b0;
        pk_load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !video_bus.data_ack) begin
                    addr_n      = '0;
                    error_n     = 1'b0;
                    fill_mode_n = fill;
                    pk_clear    = 1'b1;
                    if (fill) begin
                        pk_load     = 1'b1;
                        write_n     = 1'b1;
                        addr_hold_n = '0;
                        cnt_n       = '0;
                        state_n     = REQ;
                    end else begin
                        state_n = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (word_valid) begin
                    write_n     = 1'b1;
                    addr_hold_n = addr;
                    cnt_n       = '0;
                    state_n     = REQ;
                end
            end
            REQ: begin
                if (video_bus.data_ack) begin
                    write_n = 1'b0;
                    cnt_n   = '0;
                    state_n = RELEASE;
                end else if (cnt == CNT_LAST) begin
                    write_n = 1'b0;
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!video_bus.data_ack) begin
                    if (addr == LAST_ADDR) begin
                        state_n = DONE;
                    end else begin
                        addr_n = addr + VBW_ADDR_W'(1);
                        if (fill_mode) begin
                            write_n     = 1'b1;
                            addr_hold_n = addr + VBW_ADDR_W'(1);
                            cnt_n       = '0;
                            state_n     = REQ;
                        end else begin
                            state_n = COLLECT;
                        end
                    end
                end else if (cnt == CNT_LAST) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_video_buffer_writer.sv
// Directed and randomized checks of video_buffer_writer against a frame-image model.
module tb_video_buffer_writer;

    localparam int unsigned NW = 4;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fill = 1'b0;
    logic [23:0] fill_color = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, busy, done, error;
    logic        auto_mode = 1'b0;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    video_buffer_writer_if vbus ();

    assign vbus.data_ack = auto_mode ? auto_ack : man_ack;

    video_buffer_writer #(.WORDS(NW), .ACK_TIMEOUT(TO)) dut (
        .system_clock (clk),
        .reset        (rst),
        .start        (start),
        .fill         (fill),
        .fill_color   (fill_color),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .video_bus    (vbus),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Count done pulses.
    always @(negedge clk) if (done) done_cnt++;

    // Video block model: acks each request after a random delay and records the write.
    always begin
        @(negedge clk);
        if (!auto_mode) begin
            auto_ack = 1'b0;
        end else if (vbus.data_write && !auto_ack) begin
            repeat ($urandom_range(3)) @(negedge clk);
            wr_addr.push_back(vbus.addr_out);
            wr_data.push_back(vbus.data_out);
            auto_ack = 1'b1;
            for (int k = 0; k < 200 && vbus.data_write; k++) @(negedge clk);
            repeat ($urandom_range(3)) @(negedge clk);
            auto_ack = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; man_ack = 1'b0; auto_mode = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic f, input logic [23:0] color);
        start = 1'b1; fill = f; fill_color = color;
        tick();
        start = 1'b0; fill = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1; byte_data = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int i = 0; i < budget && done_cnt == base; i++) tick();
        repeat (4) tick();
    endtask

    function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
        return {24'd0, b0} + ({24'd0, b1} << 8) + ({24'd0, b2} << 16) + ({24'd0, b3} << 24);
    endfunction

    initial begin
        logic [7:0]  fb [16];
        logic [7:0]  r [4];
        logic [23:0] col;
        int base_w, base_d, pushed, taken, hi;

        // Reset state
        do_reset();
        chk("rst_write", 32'(vbus.data_write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_addr", vbus.addr_out, 0);
        chk("rst_data", vbus.data_out, 0);

        // First word, manual ack three cycles late, then second word to addr 1
        pulse_start(1'b0, 24'd0);
        chk("t1_ready", 32'(byte_ready), 1);
        chk("t1_busy", 32'(busy), 1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("t1_nowrite3", 32'(vbus.data_write), 0);
        send_byte(8'h44);
        chk("t1_write", 32'(vbus.data_write), 1);
        chk("t1_data", vbus.data_out, 32'h44332211);
        chk("t1_addr", vbus.addr_out, 0);
        chk("t1_ready_req", 32'(byte_ready), 0);
        tick(); tick();
        chk("t1_hold", vbus.data_out, 32'h44332211);
        man_ack = 1'b1;
        tick();
        chk("t1_wfall", 32'(vbus.data_write), 0);
        man_ack = 1'b0;
        tick();
        chk("t1_ready2", 32'(byte_ready), 1);
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'($urandom_range(255));
            send_byte(r[i]);
        end
        chk("t1_addr1", vbus.addr_out, 1);
        chk("t1_data1", vbus.data_out, pack(r[0], r[1], r[2], r[3]));
        do_reset();

        // Closed-loop random frames with a random byte_valid pattern
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) fb[i] = 8'($urandom_range(255));
            base_w = wr_addr.size();
            base_d = done_cnt;
            auto_mode = 1'b1;
            pulse_start(1'b0, 24'd0);
            pushed = 0;
            for (int c = 0; c < 2000 && pushed < 16; c++) begin
                if (byte_ready && ($urandom_range(1) == 1)) begin
                    byte_valid = 1'b1; byte_data = fb[pushed]; pushed++;
                end else begin
                    byte_valid = 1'b0; byte_data = 8'($urandom_range(255));
                end
                tick();
            end
            byte_valid = 1'b0;
            wait_done(base_d, 500);
            chk("t2_pushed", 32'(pushed), 16);
            chk("t2_nwrites", 32'(wr_addr.size() - base_w), NW);
            for (int i = 0; i < int'(NW) && base_w + i < wr_addr.size(); i++) begin
                chk("t2_waddr", wr_addr[base_w + i], 32'(i));
                chk("t2_wdata", wr_data[base_w + i],
                    pack(fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]));
            end
            chk("t2_done_once", 32'(done_cnt - base_d), 1);
            chk("t2_busy_after", 32'(busy), 0);
            byte_valid = 1'b1;
            chk("t2_17th_ready", 32'(byte_ready), 0);
            tick();
            byte_valid = 1'b0;
            auto_mode = 1'b0;
            tick();
        end

        // Fill mode: fixed colour then a random colour, no bytes consumed
        for (int f = 0; f < 2; f++) begin
            col = (f == 0) ? 24'hFF8000 : 24'($urandom);
            base_w = wr_addr.size();
            base_d = done_cnt;
            auto_mode = 1'b1;
            byte_valid = 1'b1;
            pulse_start(1'b1, col);
            taken = 0;
            for (int c = 0; c < 500 && done_cnt == base_d; c++) begin
                if (byte_ready) taken++;
                tick();
            end
            byte_valid = 1'b0;
            repeat (4) tick();
            chk("t3_taken", 32'(taken), 0);
            chk("t3_nwrites", 32'(wr_addr.size() - base_w), NW);
            for (int i = 0; i < int'(NW) && base_w + i < wr_addr.size(); i++) begin
                chk("t3_waddr", wr_addr[base_w + i], 32'(i));
                chk("t3_wdata", wr_data[base_w + i], {8'h00, col});
            end
            chk("t3_done_once", 32'(done_cnt - base_d), 1);
            chk("t3_busy_after", 32'(busy), 0);
            auto_mode = 1'b0;
            tick();
        end

        // Ack timeout in REQ
        do_reset();
        base_d = done_cnt;
        pulse_start(1'b1, 24'h123456);
        hi = 0;
        for (int c = 0; c < 40 && vbus.data_write; c++) begin
            hi++;
            tick();
        end
        chk("t4_req_cycles", 32'(hi), TO);
        chk("t4_error", 32'(error), 1);
        chk("t4_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("t4_no_done", 32'(done_cnt - base_d), 0);
        chk("t4_sticky", 32'(error), 1);
        pulse_start(1'b0, 24'd0);
        chk("t4_err_clear", 32'(error), 0);
        chk("t4_restart", 32'(busy), 1);

        // Reset mid-handshake with a stale ack
        do_reset();
        pulse_start(1'b0, 24'd0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(255)));
        man_ack = 1'b1;
        rst = 1'b1;
        tick();
        chk("t5_wdrop", 32'(vbus.data_write), 0);
        chk("t5_idle", 32'(busy), 0);
        rst = 1'b0;
        pulse_start(1'b0, 24'd0);
        chk("t5_stale_ignored", 32'(busy), 0);
        man_ack = 1'b0;
        tick();
        pulse_start(1'b0, 24'd0);
        chk("t5_resume", 32'(byte_ready), 1);
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'($urandom_range(255));
            send_byte(r[i]);
        end
        chk("t5_addr0", vbus.addr_out, 0);
        chk("t5_data", vbus.data_out, pack(r[0], r[1], r[2], r[3]));

        // Partial word discarded by reset
        do_reset();
        pulse_start(1'b0, 24'd0);
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        pulse_start(1'b0, 24'd0);
        for (int i = 0; i < 3; i++) begin
            r[i] = 8'($urandom_range(255));
            send_byte(r[i]);
        end
        chk("t5_partial_nowrite", 32'(vbus.data_write), 0);
        r[3] = 8'($urandom_range(255));
        send_byte(r[3]);
        chk("t5_partial_write", 32'(vbus.data_write), 1);
        chk("t5_partial_data", vbus.data_out, pack(r[0], r[1], r[2], r[3]));

        // start during COLLECT is ignored
        do_reset();
        pulse_start(1'b0, 24'd0);
        r[0] = 8'($urandom_range(255)); send_byte(r[0]);
        r[1] = 8'($urandom_range(255)); send_byte(r[1]);
        pulse_start(1'b1, 24'($urandom));
        chk("t6_still_collect", 32'(byte_ready), 1);
        chk("t6_no_write", 32'(vbus.data_write), 0);
        r[2] = 8'($urandom_range(255)); send_byte(r[2]);
        r[3] = 8'($urandom_range(255)); send_byte(r[3]);
        chk("t6_write", 32'(vbus.data_write), 1);
        chk("t6_addr", vbus.addr_out, 0);
        chk("t6_data", vbus.data_out, pack(r[0], r[1], r[2], r[3]));
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
